// File: rtl/rom_burst_reader_if.sv
// -----------------------------------------------------------------------------
// rom_burst_reader_if
//
// Purpose:
//   Groups every non-clock/reset signal of rom_burst_reader into one bundle:
//   the client request (start/start_addr/count/abort), the ROM address/data
//   pair, and the downstream valid/ready stream plus status.
//
// Modports:
//   slave  - the burst reader itself: consumes requests and ROM data, drives
//            the ROM address, the output stream and busy/done.
//   master - the surroundings (client + ROM + consumer): the mirror image.
//
// Signal summary:
//   start       1-cycle run request, honoured only while idle
//   start_addr  first ROM address of the run
//   count       number of words, 0..2**ADDR_W (0 = no-op)
//   abort       cancel the run in progress
//   rom_addr    address presented to the combinational ROM
//   rom_data    ROM word for rom_addr (same cycle)
//   out_data    registered word offered to the consumer
//   out_valid   out_data holds an undelivered word
//   out_ready   consumer takes the word this cycle
//   busy        reader is not idle
//   done        1-cycle pulse after the last word of a run is taken
// -----------------------------------------------------------------------------
interface rom_burst_reader_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   count;
    logic              abort;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport slave (
        input  start,
        input  start_addr,
        input  count,
        input  abort,
        input  rom_data,
        input  out_ready,
        output rom_addr,
        output out_data,
        output out_valid,
        output busy,
        output done
    );

    modport master (
        output start,
        output start_addr,
        output count,
        output abort,
        output rom_data,
        output out_ready,
        input  rom_addr,
        input  out_data,
        input  out_valid,
        input  busy,
        input  done
    );
endinterface

// File: rtl/rom_burst_reader.sv
// -----------------------------------------------------------------------------
// rom_burst_reader
//
// Purpose:
//   Sequencer in front of a combinational ROM. A client asks for `count`
//   consecutive words starting at `start_addr`; the reader walks a pointer
//   through the ROM (wrapping modulo 2**ADDR_W), registers each word and
//   streams it downstream over a valid/ready handshake at up to one word per
//   cycle. Used for boot / microcode loading.
//
// Ports:
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   bus      rom_burst_reader_if.slave - request, ROM and stream signals
//
// Timing:
//   start (sampled in IDLE) -> FETCH -> SEND with out_valid=1, i.e. the first
//   word is visible two cycles after start. With out_ready held high one word
//   is delivered per cycle; done pulses the cycle after the last transfer.
// -----------------------------------------------------------------------------
module rom_burst_reader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    rom_burst_reader_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO = '0;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;        // address currently presented to the ROM
    logic [ADDR_W:0]   r_remaining;  // words still to be fetched from the ROM
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_done;

    // -------------------------------------------------------------------------
    // Next-state values
    // -------------------------------------------------------------------------
    state_t            w_state_next;
    logic [ADDR_W-1:0] w_ptr_next;
    logic [ADDR_W:0]   w_remaining_next;
    logic [DATA_W-1:0] w_out_data_next;
    logic              w_out_valid_next;
    logic              w_done_next;

    // Pointer step and word capture are shared by FETCH and by an accepted
    // transfer in SEND, so they are computed once here.
    logic [ADDR_W-1:0] w_ptr_inc;
    logic [ADDR_W:0]   w_remaining_dec;
    logic              w_accept;

    // The increment simply overflows its ADDR_W bits, which gives the
    // required wrap from the last ROM address back to address zero.
    assign w_ptr_inc       = r_ptr + PTR_ONE;
    assign w_remaining_dec = r_remaining - CNT_ONE;
    assign w_accept        = r_out_valid && bus.out_ready;

    // -------------------------------------------------------------------------
    // Next-state / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Default: hold everything, and done is a pulse so it falls back to 0.
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_remaining_next = r_remaining;
        w_out_data_next  = r_out_data;
        w_out_valid_next = r_out_valid;
        w_done_next      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // abort is meaningless here; only start is looked at.
                if (bus.start) begin
                    if (bus.count != CNT_ZERO) begin
                        w_ptr_next       = bus.start_addr;
                        w_remaining_next = bus.count;
                        w_state_next     = ST_FETCH;
                    end else begin
                        // Empty run: acknowledge it without leaving IDLE.
                        w_done_next = 1'b1;
                    end
                end
            end

            ST_FETCH: begin
                if (bus.abort) begin
                    w_out_valid_next = 1'b0;
                    w_state_next     = ST_IDLE;
                end else begin
                    // rom_addr already equals the first address of the run,
                    // so the ROM output is the first word.
                    w_out_data_next  = bus.rom_data;
                    w_ptr_next       = w_ptr_inc;
                    w_remaining_next = w_remaining_dec;
                    w_out_valid_next = 1'b1;
                    w_state_next     = ST_SEND;
                end
            end

            ST_SEND: begin
                if (bus.abort) begin
                    // The offered word is dropped; no done for an aborted run.
                    w_out_valid_next = 1'b0;
                    w_state_next     = ST_IDLE;
                end else if (w_accept) begin
                    if (r_remaining != CNT_ZERO) begin
                        // The pointer already sits on the next word, so it can
                        // replace the accepted one in the same cycle.
                        w_out_data_next  = bus.rom_data;
                        w_ptr_next       = w_ptr_inc;
                        w_remaining_next = w_remaining_dec;
                        w_out_valid_next = 1'b1;
                    end else begin
                        w_out_valid_next = 1'b0;
                        w_done_next      = 1'b1;
                        w_state_next     = ST_IDLE;
                    end
                end
                // Otherwise out_data/out_valid stay put until the consumer
                // takes the word.
            end

            default: begin
                w_out_valid_next = 1'b0;
                w_state_next     = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_remaining <= w_remaining_next;
            r_out_data  <= w_out_data_next;
            r_out_valid <= w_out_valid_next;
            r_done      <= w_done_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.rom_addr  = r_ptr;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;

endmodule
